msrv32_dmem_responder: RTL and testbench

Data-memory responder on the far side of the msrv32 store/load data bus. It accepts AHB-Lite style transfers from the core's store path (address, write mask, write request, HTRANS) and returns HREADY, HRESP and read data. It owns a byte-writable local data RAM with a configurable number of wait states and an error response for out-of-range addresses. It is used as the data-memory model in core-level simulation and as on-chip data RAM in small builds.

---
 rtl/msrv32_dmem_pkg.sv | 29 ++
 rtl/msrv32_dmem_array.sv | 34 +++
 rtl/msrv32_dmem_responder.sv | 150 +++++++++++++++
 tb/tb_msrv32_dmem_responder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/msrv32_dmem_pkg.sv
// Shared definitions for the msrv32 data-memory responder.
// Holds the HTRANS encodings, HRESP encodings, the responder FSM state type
// and the address range check used when a transfer is accepted.
package msrv32_dmem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } dmem_state_e;

  // A byte address is in range when every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int addr_width);
    logic [31:0] upper;
    upper = addr >> (addr_width + 2);
    return (upper == 32'd0);
  endfunction

endpackage

// File: rtl/msrv32_dmem_array.sv
// Byte-writable word RAM for the data-memory responder.
// Ports:
//   clk_i    - clock, writes on rising edge
//   be_i     - per-byte write enables (bit k writes byte lane k)
//   widx_i   - word index written
//   wdata_i  - write data
//   ridx_i   - word index read (asynchronous)
//   rdata_o  - read data
// Contents are deliberately not reset.
module msrv32_dmem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] widx_i,
  input  logic [31:0]           wdata_i,
  input  logic [ADDR_WIDTH-1:0] ridx_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  // Byte-lane writes: only enabled lanes change.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (be_i[k]) begin
        mem_q[widx_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/msrv32_dmem_responder.sv
// AHB-Lite style data-memory responder for the msrv32 store/load bus.
// Accepts NONSEQ/SEQ transfers while HREADY is high, inserts WAIT_STATES
// data-phase wait cycles, and answers out-of-range addresses with a
// two-cycle ERROR response.
// Ports:
//   ms_riscv32_mp_clk_in        - clock
//   ms_riscv32_mp_rst_in        - synchronous active-high reset
//   ms_riscv32_mp_dmaddr_in     - byte address (address phase)
//   ms_riscv32_mp_dmwr_req_in   - 1 write / 0 read (address phase)
//   ms_riscv32_mp_dmwr_mask_in  - byte-lane enables (address phase)
//   ahb_htrans_in               - HTRANS
//   ms_riscv32_mp_dmdata_in     - write data (final data-phase cycle)
//   ms_riscv32_mp_dmdata_out    - read data, zero except when a read completes
//   ahb_ready_out               - HREADY
//   ahb_resp_out                - HRESP
module msrv32_dmem_responder
  import msrv32_dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic [1:0]  ahb_htrans_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ahb_ready_out,
  output logic        ahb_resp_out
);

  // Counter load value; only meaningful when WAIT_STATES > 0.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

  dmem_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [3:0]            mask_q, mask_d;

  logic                  ready_s;
  logic                  resp_s;
  logic                  valid_s;
  logic                  in_range_s;
  logic [3:0]            be_s;
  logic [31:0]           rdata_s;

  // Output decode from registered state only.
  always_comb begin
    ready_s = 1'b1;
    resp_s  = RESP_OKAY;
    case (state_q)
      ST_IDLE: begin ready_s = 1'b1; resp_s = RESP_OKAY;  end
      ST_WAIT: begin ready_s = 1'b0; resp_s = RESP_OKAY;  end
      ST_LAST: begin ready_s = 1'b1; resp_s = RESP_OKAY;  end
      ST_ERR1: begin ready_s = 1'b0; resp_s = RESP_ERROR; end
      ST_ERR2: begin ready_s = 1'b1; resp_s = RESP_ERROR; end
      default: begin ready_s = 1'b1; resp_s = RESP_OKAY;  end
    endcase
  end

  assign valid_s    = ready_s && ((ahb_htrans_in == HTRANS_NONSEQ) || (ahb_htrans_in == HTRANS_SEQ));
  assign in_range_s = addr_in_range(ms_riscv32_mp_dmaddr_in, ADDR_WIDTH);

  // Next-state, wait counter and address-phase capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (valid_s) begin
          if (in_range_s) begin
            idx_d  = ms_riscv32_mp_dmaddr_in[ADDR_WIDTH+1:2];
            wr_d   = ms_riscv32_mp_dmwr_req_in;
            mask_d = ms_riscv32_mp_dmwr_mask_in;
            if (WAIT_STATES == 0) begin
              state_d = ST_LAST;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_INIT;
            end
          end else begin
            // Error transfers never touch the RAM, so drop any write intent.
            state_d = ST_ERR1;
            cnt_d   = 4'd0;
            wr_d    = 1'b0;
            mask_d  = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
    end
  end

  // Write commits on the edge ending LAST; a reset on that edge drops it.
  assign be_s = (state_q == ST_LAST && wr_q && !ms_riscv32_mp_rst_in) ? mask_q : 4'd0;

  msrv32_dmem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk_i   (ms_riscv32_mp_clk_in),
    .be_i    (be_s),
    .widx_i  (idx_q),
    .wdata_i (ms_riscv32_mp_dmdata_in),
    .ridx_i  (idx_q),
    .rdata_o (rdata_s)
  );

  assign ms_riscv32_mp_dmdata_out = (state_q == ST_LAST && !wr_q) ? rdata_s : 32'd0;
  assign ahb_ready_out            = ready_s;
  assign ahb_resp_out             = resp_s;

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Directed bench for msrv32_dmem_responder. Three instances cover
// WAIT_STATES = 1 (d0), 0 (d1) and 3 (d2). Inputs change on the falling
// edge and outputs are checked on the falling edge.
module tb_msrv32_dmem_responder;
  import msrv32_dmem_pkg::*;

  logic        clk;
  logic        rst    [3];
  logic [31:0] addr   [3];
  logic        wr     [3];
  logic [3:0]  mask   [3];
  logic [1:0]  htrans [3];
  logic [31:0] wdata  [3];
  logic [31:0] rdata  [3];
  logic        rdy    [3];
  logic        resp   [3];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_d0 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst[0]),
    .ms_riscv32_mp_dmaddr_in(addr[0]), .ms_riscv32_mp_dmwr_req_in(wr[0]),
    .ms_riscv32_mp_dmwr_mask_in(mask[0]), .ahb_htrans_in(htrans[0]),
    .ms_riscv32_mp_dmdata_in(wdata[0]), .ms_riscv32_mp_dmdata_out(rdata[0]),
    .ahb_ready_out(rdy[0]), .ahb_resp_out(resp[0]));

  msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_d1 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst[1]),
    .ms_riscv32_mp_dmaddr_in(addr[1]), .ms_riscv32_mp_dmwr_req_in(wr[1]),
    .ms_riscv32_mp_dmwr_mask_in(mask[1]), .ahb_htrans_in(htrans[1]),
    .ms_riscv32_mp_dmdata_in(wdata[1]), .ms_riscv32_mp_dmdata_out(rdata[1]),
    .ahb_ready_out(rdy[1]), .ahb_resp_out(resp[1]));

  msrv32_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_d2 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst[2]),
    .ms_riscv32_mp_dmaddr_in(addr[2]), .ms_riscv32_mp_dmwr_req_in(wr[2]),
    .ms_riscv32_mp_dmwr_mask_in(mask[2]), .ahb_htrans_in(htrans[2]),
    .ms_riscv32_mp_dmdata_in(wdata[2]), .ms_riscv32_mp_dmdata_out(rdata[2]),
    .ahb_ready_out(rdy[2]), .ahb_resp_out(resp[2]));

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete non-pipelined transfer on instance d, started at a falling
  // edge with the instance idle; returns at the falling edge after it ends.
  task automatic xfer(input int d, input logic [31:0] a, input logic w,
                      input logic [3:0] m, input logic [31:0] wd,
                      input int exp_waits, input logic exp_err,
                      input logic [31:0] exp_rd, input string tag);
    int waits;
    addr[d] = a; wr[d] = w; mask[d] = m; wdata[d] = wd;
    htrans[d] = HTRANS_NONSEQ;
    @(negedge clk);
    htrans[d] = HTRANS_IDLE;
    if (exp_err) begin
      check({tag, "_err1"}, {30'd0, rdy[d], resp[d]}, 32'd1);
      @(negedge clk);
      check({tag, "_err2"}, {30'd0, rdy[d], resp[d]}, 32'd3);
      check({tag, "_errdata"}, rdata[d], 32'd0);
      @(negedge clk);
    end else begin
      waits = 0;
      while (rdy[d] !== 1'b1 && waits < 40) begin
        waits++;
        @(negedge clk);
      end
      check({tag, "_waits"}, waits, exp_waits);
      check({tag, "_rdyresp"}, {30'd0, rdy[d], resp[d]}, 32'd2);
      check({tag, "_data"}, rdata[d], w ? 32'd0 : exp_rd);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; addr[i] = 32'd0; wr[i] = 1'b0; mask[i] = 4'd0;
      htrans[i] = HTRANS_IDLE; wdata[i] = 32'd0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ready_d%0d", i), {31'd0, rdy[i]}, 32'd1);
      check($sformatf("reset_resp_d%0d", i), {31'd0, resp[i]}, 32'd0);
      check($sformatf("reset_data_d%0d", i), rdata[i], 32'd0);
    end

    // WAIT_STATES=1: full write, read back, masked updates.
    xfer(0, 32'h10, 1'b1, 4'b1111, 32'hAABBCCDD, 1, 1'b0, 32'd0, "ws1_wr");
    xfer(0, 32'h10, 1'b0, 4'b0000, 32'd0, 1, 1'b0, 32'hAABBCCDD, "ws1_rd");
    xfer(0, 32'h10, 1'b1, 4'b0010, 32'h0000EE00, 1, 1'b0, 32'd0, "m0010_wr");
    xfer(0, 32'h10, 1'b0, 4'b0000, 32'd0, 1, 1'b0, 32'hAABBEEDD, "m0010_rd");
    xfer(0, 32'h10, 1'b1, 4'b1100, 32'h11220000, 1, 1'b0, 32'd0, "m1100_wr");
    xfer(0, 32'h10, 1'b0, 4'b0000, 32'd0, 1, 1'b0, 32'h1122EEDD, "m1100_rd");
    xfer(0, 32'h13, 1'b1, 4'b0000, 32'hFFFFFFFF, 1, 1'b0, 32'd0, "m0000_wr");
    xfer(0, 32'h10, 1'b0, 4'b0000, 32'd0, 1, 1'b0, 32'h1122EEDD, "m0000_rd");

    // Out-of-range write must not alias onto word 0.
    xfer(0, 32'h0, 1'b1, 4'b1111, 32'h01020304, 1, 1'b0, 32'd0, "w0_wr");
    xfer(0, 32'h00001000, 1'b1, 4'b1111, 32'hFFFFFFFF, 0, 1'b1, 32'd0, "oor");
    xfer(0, 32'h0, 1'b0, 4'b0000, 32'd0, 1, 1'b0, 32'h01020304, "w0_rd");

    // WAIT_STATES=0: pipelined write then read of the same word.
    addr[1] = 32'h20; wr[1] = 1'b1; mask[1] = 4'b1111; wdata[1] = 32'hDEADBEEF;
    htrans[1] = HTRANS_NONSEQ;
    @(negedge clk);
    check("pipe_wr_ready", {31'd0, rdy[1]}, 32'd1);
    wr[1] = 1'b0; mask[1] = 4'b0000;
    @(negedge clk);
    htrans[1] = HTRANS_IDLE;
    check("pipe_rd_ready", {31'd0, rdy[1]}, 32'd1);
    check("pipe_rd_data", rdata[1], 32'hDEADBEEF);
    @(negedge clk);

    // IDLE and BUSY with write request asserted: no memory effect.
    addr[1] = 32'h20; wr[1] = 1'b1; mask[1] = 4'b1111; wdata[1] = 32'h0;
    htrans[1] = HTRANS_IDLE;
    @(negedge clk);
    check("idle_ready", {30'd0, rdy[1], resp[1]}, 32'd2);
    htrans[1] = HTRANS_BUSY;
    @(negedge clk);
    check("busy_ready", {30'd0, rdy[1], resp[1]}, 32'd2);
    htrans[1] = HTRANS_IDLE;
    xfer(1, 32'h20, 1'b0, 4'b0000, 32'd0, 0, 1'b0, 32'hDEADBEEF, "ws0_rd");

    // WAIT_STATES=3: reset in the second wait cycle drops the write.
    xfer(2, 32'h30, 1'b1, 4'b1111, 32'h0BADF00D, 3, 1'b0, 32'd0, "ws3_wr");
    addr[2] = 32'h30; wr[2] = 1'b1; mask[2] = 4'b1111; wdata[2] = 32'h12345678;
    htrans[2] = HTRANS_NONSEQ;
    @(negedge clk);
    htrans[2] = HTRANS_IDLE;
    check("ws3_wait1", {31'd0, rdy[2]}, 32'd0);
    @(negedge clk);
    check("ws3_wait2", {31'd0, rdy[2]}, 32'd0);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {30'd0, rdy[2], resp[2]}, 32'd2);
    check("rst_mid_data", rdata[2], 32'd0);
    xfer(2, 32'h30, 1'b0, 4'b0000, 32'd0, 3, 1'b0, 32'h0BADF00D, "ws3_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
